serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width in bits; legal range 2..64.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on the rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 start  input  1  SHALL request one operation; it is sampled only in state IDLE.
REQ-005 sub  input  1  SHALL select the operation: 0 = a+b, 1 = a-b; it is sampled with start.
REQ-006 a  input  WIDTH  SHALL be operand A, latched on an accepted start.
REQ-007 b  input  WIDTH  SHALL be operand B, latched on an accepted start.
REQ-008 busy  output  1  SHALL be high while in state RUN.
REQ-009 done  output  1  SHALL be a one-cycle pulse, high only in state DONE.
REQ-010 sum  output  WIDTH  SHALL present the result register.
REQ-011 cout  output  1  SHALL be the final carry out of the MSB; for subtraction it is the inverted borrow.
REQ-012 overflow  output  1  SHALL be the signed overflow flag: carry into the MSB XOR carry out of the MSB.

Function
REQ-013 The block SHALL add bit-serially through one full-adder cell, LSB first, one bit per clock, using a carry flip-flop.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 FSM transitions:
- IDLE -> RUN on start = 1.
- RUN -> DONE after exactly WIDTH bit cycles.
- DONE -> IDLE unconditionally.
REQ-016 On an accepted start, the block SHALL:
- latch a into the A shift register;
- latch b, or ~b when sub = 1, into the B shift register;
- load the carry flip-flop with sub;
- clear the bit counter;
- clear sum, cout and overflow.
REQ-017 In each RUN cycle, the block SHALL:
- shift the full-adder sum bit into sum from the MSB end, so that after WIDTH shifts bit 0 holds the first result bit;
- shift A and B right by one;
- load the carry flip-flop with the cell's carry out;
- increment the counter.
REQ-018 On the final RUN cycle (counter = WIDTH-1), the block SHALL capture the carry in to the cell as the MSB carry-in, for the overflow computation.
REQ-019 On entry to DONE, cout and overflow SHALL be valid; sum, cout and overflow SHALL then hold until the next accepted start or reset.
REQ-020 Latency: start sampled at edge 0 -> busy high for edges 1..WIDTH -> done high for exactly one cycle after edge WIDTH+1.
REQ-021 start in RUN or DONE SHALL be ignored, with no queuing; a back-to-back start is accepted in the IDLE cycle after done.
REQ-022 Changes to a, b and sub after acceptance SHALL NOT affect the operation in progress.
REQ-023 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL NOT wrap during RUN.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH; carry out beyond the MSB is reported only through cout.

Reset
REQ-025 Asserting reset SHALL immediately force:
- state = IDLE;
- busy = 0, done = 0;
- sum = 0, cout = 0, overflow = 0;
- counter = 0, carry = 0, shift registers = 0.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse; the first start after reset release is accepted normally.

Structure
REQ-027 State encodings and the default WIDTH SHALL live in a shared header/package (serial_add_pkg) used by the controller and the bench.
REQ-028 The datapath SHALL instantiate exactly one sub-module: the team's existing one-bit full-adder cell (onebitAdder), with ports a, b, ci, s, co.
REQ-029 All other logic (FSM, counter, shift registers, carry flip-flop) SHALL be local to serial_add_ctrl, with no combinational path from start to done.

Verification
REQ-030 Add, WIDTH=4: a=0011, b=0101, sub=0 -> done at edge 5 with sum=1000, cout=0, overflow=1.
REQ-031 Subtract, WIDTH=4: a=0101, b=0011, sub=1 -> sum=0010, cout=1, overflow=0; then a=0011, b=0101 -> sum=1110, cout=0, overflow=0.
REQ-032 Wrap-around, WIDTH=32: a=FFFFFFFF, b=00000001, sub=0 -> sum=00000000, cout=1, overflow=0; a=7FFFFFFF, b=1 -> sum=80000000, overflow=1.
REQ-033 Handshake: pulse start at edges 2 and 3 during RUN with different operands -> exactly one done, result from the first operands only; busy high for exactly WIDTH cycles.
REQ-034 Reset mid-op: assert reset at RUN cycle 2 -> all outputs 0 at once, no done; the next operation (9+6, WIDTH=4) returns sum=1111.
REQ-035 Back-to-back: start held high continuously -> operations complete every WIDTH+2 cycles, each done a single-cycle pulse.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_t        : controller state encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand/result width in bits
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/onebitAdder.sv
// One-bit full-adder cell.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module onebitAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, one bit per
// clock. A start in IDLE latches the operands; WIDTH RUN cycles later the
// block spends one cycle in DONE with the result valid, then returns to IDLE.
//   clk      : clock, rising edge
//   reset    : asynchronous active-high reset
//   start    : request an operation (sampled in IDLE only)
//   sub      : 0 = a+b, 1 = a-b (sampled with start)
//   a, b     : operands (latched on an accepted start)
//   busy     : high while in RUN
//   done     : one-cycle pulse in DONE
//   sum      : result register
//   cout     : carry out of the MSB (inverted borrow for subtraction)
//   overflow : signed overflow flag
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic             w_accept;

  onebitAdder u_fa (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and status outputs; both depend on state only, so there is
  // no combinational path from start to done.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: shift registers, carry flip-flop, counter and result flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1: invert B and seed the carry with sub.
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == RUN) begin
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        // r_carry is the carry into the MSB on this cycle.
        r_cout <= w_co;
        r_ovf  <= r_carry ^ w_co;
      end
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a 4-bit and a 32-bit instance
// driven from a directed vector table plus hand-written sequences for the
// handshake, mid-operation reset and back-to-back cases.
module tb_serial_add_ctrl;
  import serial_add_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start4, sub4, busy4, done4, cout4, ovf4;
  logic [3:0]  a4, b4, sum4;
  logic        start32, sub32, busy32, done32, cout32, ovf32;
  logic [31:0] a32, b32, sum32;

  int n_total = 0;
  int n_bad   = 0;

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
  );

  serial_add_ctrl #(.WIDTH(DEFAULT_WIDTH)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .sum(sum32), .cout(cout32), .overflow(ovf32)
  );

  typedef struct {
    logic        w32;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] es;
    logic        ec;
    logic        eo;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One operation on the selected instance; checks latency, busy length,
  // done pulse width and the result.
  task automatic do_op(input logic w32, input logic s, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] es,
                       input logic ec, input logic eo, input string nm);
    int          busy_cnt;
    int          lat;
    logic        got;
    logic [31:0] rs;
    logic        rc, ro;
    int          w;
    w        = w32 ? DEFAULT_WIDTH : 4;
    busy_cnt = 0;
    lat      = 0;
    got      = 1'b0;
    rs       = '0;
    rc       = 1'b0;
    ro       = 1'b0;
    @(negedge clk);
    if (w32) begin start32 = 1'b1; sub32 = s; a32 = av; b32 = bv; end
    else begin start4 = 1'b1; sub4 = s; a4 = av[3:0]; b4 = bv[3:0]; end
    @(negedge clk);
    // Scramble the inputs: the operation in flight must not see them.
    start4 = 1'b0; start32 = 1'b0;
    a4 = ~a4; b4 = ~b4; sub4 = ~sub4;
    a32 = ~a32; b32 = ~b32; sub32 = ~sub32;
    for (int c = 0; c < 80; c++) begin
      if (w32 ? done32 : done4) begin
        got = 1'b1;
        lat = c;
        rs  = w32 ? sum32 : {28'd0, sum4};
        rc  = w32 ? cout32 : cout4;
        ro  = w32 ? ovf32 : ovf4;
        break;
      end
      if (w32 ? busy32 : busy4) busy_cnt++;
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, 64'(got), 64'd1);
    chk({nm, "_latency"}, 64'(lat), 64'(w));
    chk({nm, "_busy_cycles"}, 64'(busy_cnt), 64'(w));
    chk({nm, "_sum"}, 64'(rs), 64'(es));
    chk({nm, "_cout_ovf"}, {62'd0, rc, ro}, {62'd0, ec, eo});
    @(negedge clk);
    chk({nm, "_done_pulse"}, 64'(w32 ? done32 : done4), 64'd0);
    $display("op %s: w=%0d sub=%0b a=%0h b=%0h -> sum=%0h cout=%0b ovf=%0b",
             nm, w, s, av, bv, rs, rc, ro);
  endtask

  initial begin
    int          dcnt;
    int          bcnt;
    logic [3:0]  hs_sum;
    logic        hs_ovf;

    vt[0]  = '{1'b0, 1'b0, 32'h3, 32'h5, 32'h8, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 1'b1, 32'h5, 32'h3, 32'h2, 1'b1, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'h3, 32'h5, 32'hE, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 32'hF, 32'hF, 32'hE, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'h8, 32'h1, 32'h7, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1};
    vt[8]  = '{1'b1, 1'b1, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b1};
    vt[10] = '{1'b1, 1'b0, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 32'h9, 32'h6, 32'hF, 1'b0, 1'b0};

    start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
    start32 = 1'b0; sub32 = 1'b0; a32 = '0; b32 = '0;
    reset = 1'b1;
    #1;
    chk("reset_w4", {59'd0, busy4, done4, cout4, ovf4, |sum4}, 64'd0);
    chk("reset_w32", {59'd0, busy32, done32, cout32, ovf32, |sum32}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(vt[i].w32, vt[i].s, vt[i].a, vt[i].b, vt[i].es, vt[i].ec, vt[i].eo,
            $sformatf("vec%0d", i));
    end

    // Handshake: extra starts at edges 2 and 3 while running are ignored.
    @(negedge clk);
    start4 = 1'b1; sub4 = 1'b0; a4 = 4'h3; b4 = 4'h5;
    dcnt = 0; bcnt = 0; hs_sum = '0; hs_ovf = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy4) bcnt++;
      if (done4) begin dcnt++; hs_sum = sum4; hs_ovf = ovf4; end
      start4 = (c == 1 || c == 2);
      if (c == 1 || c == 2) begin a4 = 4'hF; b4 = 4'hF; sub4 = 1'b1; end
    end
    start4 = 1'b0;
    chk("hs_done_count", 64'(dcnt), 64'd1);
    chk("hs_busy_cycles", 64'(bcnt), 64'd4);
    chk("hs_result", {59'd0, hs_sum, hs_ovf}, {59'd0, 4'h8, 1'b1});
    $display("op handshake: dones=%0d busy=%0d sum=%0h ovf=%0b", dcnt, bcnt, hs_sum, hs_ovf);

    // Reset during RUN cycle 2: everything clears at once, no done.
    @(negedge clk);
    start4 = 1'b1; sub4 = 1'b0; a4 = 4'h1; b4 = 4'h0;
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_outputs", {59'd0, busy4, done4, cout4, ovf4, |sum4}, 64'd0);
    dcnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done4) dcnt++;
    end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done4) dcnt++;
    end
    chk("midrst_no_done", 64'(dcnt), 64'd0);
    $display("op midreset: dones_after_abort=%0d", dcnt);
    do_op(1'b0, 1'b0, 32'h9, 32'h6, 32'hF, 1'b0, 1'b0, "after_reset");

    // Back-to-back: start held high, a done every WIDTH+2 = 6 cycles.
    @(negedge clk);
    start4 = 1'b1; sub4 = 1'b0; a4 = 4'h3; b4 = 4'h5;
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_done_c%0d", c), 64'(done4), 64'((c % 6) == 4));
      if (done4) begin
        dcnt++;
        chk($sformatf("b2b_sum_c%0d", c), 64'(sum4), 64'h8);
      end
    end
    start4 = 1'b0;
    chk("b2b_done_count", 64'(dcnt), 64'd3);
    $display("op back2back: dones=%0d in 20 cycles", dcnt);
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
